// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C transaction arbiter slice.
package i2c_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      BUSY,
      CHECK,
      BACKOFF,
      RELEASE
   } arb_state_t;

   localparam logic       ACK_OK             = 1'b0;
   localparam logic [7:0] ADV7513_SLAVE_ADDR = 8'h72;

   localparam int REQ_INIT = 0;
   localparam int REQ_HPD  = 1;

   // One transaction is {slave_addr, reg_addr, payload}, 8 bits each
   localparam int TXN_W       = 24;
   localparam int SLAVE_LSB   = 16;
   localparam int REG_LSB     = 8;
   localparam int PAYLOAD_LSB = 0;

   typedef struct packed {
      logic [7:0] slave_addr;
      logic [7:0] reg_addr;
      logic [7:0] payload;
   } i2c_txn_t;

endpackage

// File: rtl/i2c_transaction_arbiter_rr_grant.sv
// Two-way round-robin selector; the last winner loses the next tie.
module i2c_rr_grant
   import i2c_arb_pkg::*;
(
   input  logic       clock_25,
   input  logic       reset,
   input  logic [1:0] req_valid,
   input  logic       enable,
   output logic [1:0] grant
);

   logic last_grant;

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (&req_valid) grant = last_grant ? 2'b01 : 2'b10;
         else            grant = req_valid;
      end
   end

   // Resetting to the HPD side lets the init sequencer win the first tie
   always_ff @(posedge clock_25) begin
      if (reset)       last_grant <= 1'(REQ_HPD);
      else if (|grant) last_grant <= grant[1];
   end

endmodule

// File: rtl/i2c_transaction_arbiter.sv
// Arbitrates the shared I2C controller between init and HPD requesters,
// with NACK retry/backoff and a tick-based transaction timeout.
module i2c_transaction_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int MAX_RETRIES   = 3,
   parameter int TIMEOUT_TICKS = 4096,
   parameter int BACKOFF_TICKS = 2
) (
   input  logic        clock_25,
   input  logic        reset,
   input  logic        tick_100khz,
   input  logic [1:0]  req_valid,
   input  logic [47:0] req_data,
   output logic [1:0]  req_done,
   output logic [1:0]  req_error,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        i2c_start,
   output logic [7:0]  i2c_slave_address,
   output logic [15:0] i2c_register_data,
   input  logic        i2c_stop,
   input  logic        i2c_ack
);

   localparam int RW = $clog2(MAX_RETRIES + 1);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam int BW = $clog2(BACKOFF_TICKS + 1);

   arb_state_t    state, state_nxt;
   i2c_txn_t      txn;
   logic [1:0]    sel;
   logic [RW-1:0] retry_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [BW-1:0] bo_cnt;
   logic          stop_prev, ack_q;
   logic          stop_fall, tmo_hit, bo_done;
   logic          done_set, err_set;

   i2c_rr_grant u_rr (
      .clock_25  (clock_25),
      .reset     (reset),
      .req_valid (req_valid),
      .enable    (state == IDLE),
      .grant     (sel)
   );

   assign stop_fall         = stop_prev & ~i2c_stop;
   assign tmo_hit           = tick_100khz && (tmo_cnt == TW'(TIMEOUT_TICKS - 1));
   assign bo_done           = tick_100khz && (bo_cnt == BW'(BACKOFF_TICKS - 1));
   assign i2c_slave_address = txn.slave_addr;
   assign i2c_register_data = {txn.reg_addr, txn.payload};

   // Progress on the controller handshake takes priority over a coincident timeout
   always_comb begin
      state_nxt = state;
      done_set  = 1'b0;
      err_set   = 1'b0;
      i2c_start = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE:    if (|sel) state_nxt = ISSUE;
         ISSUE: begin
            i2c_start = 1'b1;
            if (i2c_stop) state_nxt = BUSY;
            else if (tmo_hit) begin
               i2c_start = 1'b0;
               err_set   = 1'b1;
               state_nxt = RELEASE;
            end
         end
         BUSY: begin
            if (stop_fall) state_nxt = CHECK;
            else if (tmo_hit) begin
               err_set   = 1'b1;
               state_nxt = RELEASE;
            end
         end
         CHECK: begin
            if (ack_q == ACK_OK) begin
               done_set  = 1'b1;
               state_nxt = RELEASE;
            end else if (retry_cnt < RW'(MAX_RETRIES)) begin
               state_nxt = BACKOFF;
            end else begin
               err_set   = 1'b1;
               state_nxt = RELEASE;
            end
         end
         BACKOFF: if (bo_done) state_nxt = ISSUE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock_25) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= 2'b00;
         req_done  <= 2'b00;
         req_error <= 2'b00;
         txn       <= '0;
         retry_cnt <= '0;
         tmo_cnt   <= '0;
         bo_cnt    <= '0;
         stop_prev <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         stop_prev <= i2c_stop;
         req_done  <= done_set ? grant : 2'b00;
         req_error <= err_set  ? grant : 2'b00;

         if (state == IDLE && |sel) begin
            grant     <= sel;
            txn       <= sel[REQ_HPD] ? req_data[TXN_W*REQ_HPD +: TXN_W]
                                      : req_data[TXN_W*REQ_INIT +: TXN_W];
            retry_cnt <= '0;
         end else if (state == RELEASE) begin
            grant <= 2'b00;
         end

         if (state == BUSY && stop_fall) ack_q <= i2c_ack;

         if (state_nxt == ISSUE && state != ISSUE)
            tmo_cnt <= '0;
         else if ((state == ISSUE || state == BUSY) && tick_100khz &&
                  tmo_cnt != TW'(TIMEOUT_TICKS))
            tmo_cnt <= tmo_cnt + 1'b1;

         if (state == CHECK && state_nxt == BACKOFF) begin
            retry_cnt <= retry_cnt + 1'b1;
            bo_cnt    <= '0;
         end else if (state == BACKOFF && tick_100khz && bo_cnt != BW'(BACKOFF_TICKS)) begin
            bo_cnt <= bo_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2c_transaction_arbiter.sv
// Directed + randomized bench with a behavioural controller and arbitration model.
module tb_i2c_transaction_arbiter;
   import i2c_arb_pkg::*;

   localparam int MAXR = 3;
   localparam int BOFF = 2;
   localparam int TMO  = 4096;

   logic        clock_25 = 1'b0, reset = 1'b1, tick_100khz = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [47:0] req_data = '0;
   logic [1:0]  req_done, req_error, grant;
   logic        busy, i2c_start, i2c_stop, i2c_ack;
   logic [7:0]  i2c_slave_address;
   logic [15:0] i2c_register_data;

   i2c_transaction_arbiter #(.MAX_RETRIES(MAXR), .TIMEOUT_TICKS(TMO), .BACKOFF_TICKS(BOFF)) dut (
      .clock_25(clock_25), .reset(reset), .tick_100khz(tick_100khz),
      .req_valid(req_valid), .req_data(req_data), .req_done(req_done),
      .req_error(req_error), .grant(grant), .busy(busy), .i2c_start(i2c_start),
      .i2c_slave_address(i2c_slave_address), .i2c_register_data(i2c_register_data),
      .i2c_stop(i2c_stop), .i2c_ack(i2c_ack)
   );

   always #5 clock_25 = ~clock_25;

   int total = 0, bad = 0;
   int cyc = 0, tick_cnt = 0, pulse_count = 0, pulse_tick = 0;
   int starts = 0, hold_cyc = 40, cur = 0, model_last = 1;
   int nack_left[2];
   bit stuck = 0, ctrl_abort = 0;
   int start_ticks[$], fall_ticks[$];
   logic [7:0]  cap_addr[$];
   logic [15:0] cap_data[$];

   // 100 kHz enable: one pulse every 4 clocks, changed just after the edge
   initial forever begin
      @(posedge clock_25); #1;
      cyc++;
      tick_100khz = (cyc % 4 == 0);
      if (tick_100khz) tick_cnt++;
   end

   always @(negedge clock_25) pulse_count <= pulse_count + $countones(req_done | req_error);

   // Controller model: accepts a start, holds busy, then reports ACK/NACK
   initial begin
      i2c_stop = 1'b0; i2c_ack = 1'b0;
      nack_left[0] = 0; nack_left[1] = 0;
      forever begin
         @(negedge clock_25);
         if (i2c_start === 1'b1 && !reset && !ctrl_abort) begin
            starts++;
            start_ticks.push_back(tick_cnt);
            cap_addr.push_back(i2c_slave_address);
            cap_data.push_back(i2c_register_data);
            cur = grant[1] ? 1 : 0;
            @(negedge clock_25);
            i2c_stop = 1'b1;
            i2c_ack  = (nack_left[cur] > 0);
            if (nack_left[cur] > 0) nack_left[cur]--;
            for (int k = 0; ; k++) begin
               if (ctrl_abort) break;
               if (!stuck && k >= hold_cyc) break;
               if (stuck && req_error != 2'b00) break;
               @(negedge clock_25);
            end
            i2c_stop = 1'b0;
            fall_ticks.push_back(tick_cnt);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [1:0] v);
      int w;
      if (v == 2'b11) w = (model_last == 0) ? 1 : 0;
      else            w = v[1] ? 1 : 0;
      model_last = w;
      return w;
   endfunction

   function automatic int tries(input int n);
      return (n > MAXR) ? MAXR + 1 : n + 1;
   endfunction

   task automatic clear_caps();
      starts = 0;
      start_ticks.delete(); fall_ticks.delete();
      cap_addr.delete(); cap_data.delete();
   endtask

   task automatic wait_starts(input string tag, input int n);
      for (int c = 0; c < 400 && starts < n; c++) @(negedge clock_25);
      chk(tag, 32'(starts >= n), 1);
   endtask

   // Wait for the owner's pulse and check outcome, attempts, latched data and backoff gaps
   task automatic serve(input string tag, input int who, input bit err,
                        input logic [23:0] txn, input int attempts, input int budget);
      bit got = 0;
      logic [1:0] oh = (who == 1) ? 2'b10 : 2'b01;
      for (int c = 0; c < budget && !got; c++) begin
         @(negedge clock_25);
         got = |(req_done | req_error);
      end
      pulse_tick = tick_cnt;
      chk({tag, "_seen"},  32'(got), 1);
      chk({tag, "_done"},  32'(req_done),  err ? 0 : 32'(oh));
      chk({tag, "_err"},   32'(req_error), err ? 32'(oh) : 0);
      chk({tag, "_grant"}, 32'(grant), 32'(oh));
      chk({tag, "_start"}, 32'(i2c_start), 0);
      chk({tag, "_tries"}, 32'(starts), 32'(attempts));
      foreach (cap_addr[k]) begin
         chk({tag, "_addr"}, 32'(cap_addr[k]), 32'(txn[23:16]));
         chk({tag, "_data"}, 32'(cap_data[k]), 32'(txn[15:0]));
      end
      for (int k = 1; k < start_ticks.size() && k <= fall_ticks.size(); k++)
         chk({tag, "_gap"}, 32'(start_ticks[k] - fall_ticks[k-1] >= BOFF), 1);
      if (got) req_valid = req_valid & ~(req_done | req_error);
      else     req_valid = req_valid & ~oh;
      clear_caps();
      @(negedge clock_25);
      chk({tag, "_onecyc"}, 32'(req_done | req_error), 0);
      chk({tag, "_rel"},    32'(grant), 0);
   endtask

   initial begin
      logic [23:0] d0, d1, t0x;
      logic [1:0]  v;
      int first, second, n0, n1, t0, pc;

      repeat (3) @(negedge clock_25);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_start", 32'(i2c_start), 0);
      chk("rst_addr",  32'(i2c_slave_address), 0);
      chk("rst_data",  32'(i2c_register_data), 0);
      chk("rst_done",  32'(req_done), 0);
      chk("rst_err",   32'(req_error), 0);
      reset = 1'b0;
      @(negedge clock_25);

      // Contention twice: the tie-break must alternate from the reset owner
      for (int r = 0; r < 2; r++) begin
         d0 = 24'($urandom); d1 = 24'($urandom);
         hold_cyc = $urandom_range(20, 60);
         req_data = {d1, d0};
         clear_caps();
         req_valid = 2'b11;
         first  = rr_pick(2'b11);
         second = rr_pick(first == 0 ? 2'b10 : 2'b01);
         chk("cont_first_is_init", 32'(first), 0);
         serve("cont_a", first,  0, first  ? d1 : d0, 1, 2000);
         serve("cont_b", second, 0, second ? d1 : d0, 1, 2000);
      end

      // Single request with one-cycle grant latency
      hold_cyc = 120;
      d0 = {ADV7513_SLAVE_ADDR, 8'h41, 8'h10};
      req_data[23:0] = d0;
      clear_caps();
      req_valid = 2'b01;
      void'(rr_pick(2'b01));
      @(negedge clock_25);
      chk("lat_start", 32'(i2c_start), 1);
      chk("lat_grant", 32'(grant), 1);
      chk("lat_busy",  32'(busy), 1);
      pc = pulse_count;
      serve("single", 0, 0, d0, 1, 2000);
      chk("single_pulses", 32'(pulse_count - pc), 1);

      // Permanent NACK, with requester data scrambled after the grant
      hold_cyc = 30;
      nack_left[0] = 9;
      d0 = 24'($urandom);
      req_data[23:0] = d0;
      clear_caps();
      req_valid = 2'b01;
      void'(rr_pick(2'b01));
      wait_starts("nack_first", 1);
      req_data[23:0] = ~d0;
      serve("nack_all", 0, 1, d0, tries(9), 4000);
      nack_left[0] = 0;

      // Two NACKs then ACK
      nack_left[0] = 2;
      d0 = 24'($urandom);
      req_data[23:0] = d0;
      clear_caps();
      req_valid = 2'b01;
      void'(rr_pick(2'b01));
      serve("nack2", 0, 0, d0, tries(2), 4000);

      // Timeout with stop stuck high; req1 waiting then takes the bus
      stuck = 1;
      d0 = 24'($urandom); d1 = 24'($urandom);
      req_data = {d1, d0};
      clear_caps();
      req_valid = 2'b01;
      void'(rr_pick(2'b01));
      wait_starts("tmo_first", 1);
      t0 = start_ticks[0];
      req_valid[1] = 1'b1;
      serve("tmo", 0, 1, d0, 1, 20000);
      chk("tmo_ticks", 32'((pulse_tick - t0) >= TMO - 1 && (pulse_tick - t0) <= TMO), 1);
      stuck = 0;
      hold_cyc = 30;
      void'(rr_pick(2'b10));
      serve("tmo_next", 1, 0, d1, 1, 2000);

      // Reset while BUSY: immediate return to idle, then a fresh grant
      hold_cyc = 400;
      d1 = 24'($urandom);
      req_data[47:24] = d1;
      clear_caps();
      req_valid = 2'b10;
      wait_starts("rstb_first", 1);
      repeat (6) @(negedge clock_25);
      chk("rstb_pre_busy", 32'(busy), 1);
      pc = pulse_count;
      reset = 1'b1; ctrl_abort = 1;
      @(negedge clock_25);
      chk("rstb_grant", 32'(grant), 0);
      chk("rstb_busy",  32'(busy), 0);
      chk("rstb_start", 32'(i2c_start), 0);
      chk("rstb_pulse", 32'(req_done | req_error), 0);
      @(negedge clock_25);
      reset = 1'b0; ctrl_abort = 0;
      clear_caps();
      model_last = 1;
      hold_cyc = 30;
      void'(rr_pick(2'b10));
      serve("rstb_regrant", 1, 0, d1, 1, 2000);
      chk("rstb_pulses", 32'(pulse_count - pc), 1);

      // Randomized mixes checked against the arbitration/retry model
      for (int it = 0; it < 8; it++) begin
         v  = 2'($urandom_range(1, 3));
         d0 = 24'($urandom); d1 = 24'($urandom);
         n0 = $urandom_range(0, 5); n1 = $urandom_range(0, 5);
         hold_cyc = $urandom_range(20, 80);
         nack_left[0] = n0; nack_left[1] = n1;
         req_data = {d1, d0};
         clear_caps();
         req_valid = v;
         first = rr_pick(v);
         serve("rnd_a", first, (first ? n1 : n0) > MAXR, first ? d1 : d0,
               tries(first ? n1 : n0), 4000);
         if (v == 2'b11) begin
            second = rr_pick(first ? 2'b01 : 2'b10);
            serve("rnd_b", second, (second ? n1 : n0) > MAXR, second ? d1 : d0,
                  tries(second ? n1 : n0), 4000);
         end
         nack_left[0] = 0; nack_left[1] = 0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
